// File: rtl/pixel_aer_pkg.sv
// Shared types and helpers for the AER pixel row: request FSM states, refractory
// counter width and a saturating adder.
package pixel_aer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StSel     = 2'd2,
    StRelease = 2'd3
  } aer_state_e;

  localparam int unsigned REFR_W = 8;

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned lim);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    return (s > longint'(lim)) ? lim : 32'(s);
  endfunction

endpackage

// File: rtl/pixel_cell_sync.sv
// One AER pixel: registered set/reset latch plus, with PIXEL_REFRACTORY_EN defined,
// a refractory down-counter that blocks new spikes after each clear.
module pixel_cell_sync
  import pixel_aer_pkg::*;
#(
  parameter int unsigned REFR_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic spk,
  input  logic acky,
  input  logic ackx,
  output logic q,
  output logic q_next,
  output logic blocked
);

  logic clr;
  logic set;

  assign clr = acky & ackx;

`ifdef PIXEL_REFRACTORY_EN
  logic [REFR_W-1:0] refr_q;

  assign blocked = acky | q | (refr_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      refr_q <= '0;
    end else if (clr) begin
      refr_q <= REFR_W'(REFR_CYC);
    end else if (refr_q != '0) begin
      refr_q <= refr_q - 1'b1;
    end
  end
`else
  logic unused_refr;
  assign unused_refr = ^REFR_W'(REFR_CYC);
  assign blocked     = acky | q;
`endif

  assign set    = spk & ~blocked;
  // Set needs acky=0 and clear needs acky=1, so they never collide.
  assign q_next = clr ? 1'b0 : (q | set);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/pixel_row_aer.sv
// Row of N_COLS AER pixels with row request FSM, column requests and a saturating
// dropped-spike counter. Optional refractory period via PIXEL_REFRACTORY_EN.
module pixel_row_aer
  import pixel_aer_pkg::*;
#(
  parameter int unsigned N_COLS   = 8,
  parameter int unsigned DROP_W   = 8,
  parameter int unsigned REFR_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_COLS-1:0] spk_in,
  input  logic              acky,
  input  logic [N_COLS-1:0] ackx_pulse,
  output logic              reqy,
  output logic [N_COLS-1:0] reqx,
  output logic [N_COLS-1:0] q_latch,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned DropMax = 32'((64'(1) << DROP_W) - 1);

  logic [N_COLS-1:0] q_next;
  logic [N_COLS-1:0] blocked;
  logic [N_COLS-1:0] drop_vec;
  logic              any_d;
  int unsigned       n_drop;
  aer_state_e        state_q;

  for (genvar i = 0; i < N_COLS; i++) begin : g_cell
    pixel_cell_sync #(
      .REFR_CYC(REFR_CYC)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .spk    (spk_in[i]),
      .acky   (acky),
      .ackx   (ackx_pulse[i]),
      .q      (q_latch[i]),
      .q_next (q_next[i]),
      .blocked(blocked[i])
    );
  end

  assign reqx     = q_latch & {N_COLS{acky}};
  assign drop_vec = spk_in & blocked;
  // Transitions look at the post-edge latch state so reqy tracks q_latch without lag.
  assign any_d    = |q_next;

  always_comb begin
    n_drop = 0;
    for (int i = 0; i < N_COLS; i++) begin
      n_drop = n_drop + {31'd0, drop_vec[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= DROP_W'(sat_add(32'(drop_cnt), n_drop, DropMax));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      reqy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_d && !acky) begin
            state_q <= StReq;
            reqy    <= 1'b1;
          end
        end
        StReq: begin
          if (acky) begin
            state_q <= StSel;
            reqy    <= any_d;
          end
        end
        StSel: begin
          if (!any_d) begin
            state_q <= StRelease;
            reqy    <= 1'b0;
          end else if (!acky) begin
            state_q <= StReq;
            reqy    <= 1'b1;
          end else begin
            reqy    <= 1'b1;
          end
        end
        StRelease: begin
          if (!acky) begin
            state_q <= any_d ? StReq : StIdle;
            reqy    <= any_d;
          end
        end
        default: begin
          state_q <= StIdle;
          reqy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pixel_row_aer.md
Name: pixel_row_aer

Overview:
- Parametrised row of N_COLS spiking pixels with an AER row/column handshake toward the arbiter.
- Each pixel holds a registered set/reset latch: spikes set it, and a column acknowledge under row selection clears it.
- Adds clocked operation, a per-row request FSM, per-column request outputs, a dropped-spike counter and an optional refractory period.
- Sits between the spike sources (neuron/sensor array) and the row/column AER arbiters.

Parameters:
- N_COLS, 8, number of pixels (columns) in the row.
- DROP_W, 8, width of the saturating dropped-spike counter.
- REFR_CYC, 4, refractory length in clk cycles; used only with the optional feature; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- spk_in  input  N_COLS  per-pixel spike level, sampled each clk.
- acky  input  1  row acknowledge from row arbiter (level).
- ackx_pulse  input  N_COLS  per-column acknowledge pulses; meaningful only while acky=1.
- reqy  output  1  row request to row arbiter.
- reqx  output  N_COLS  column requests, reqx[i] = q_latch[i] & acky (combinational).
- q_latch  output  N_COLS  pixel latch state (registered).
- drop_cnt  output  DROP_W  count of spikes lost, saturating.

Behaviour:
- Reset (rst=1 at edge): q_latch=0, state=IDLE, drop_cnt=0, refractory counters=0. reqy=0 and reqx=0 in the following cycle.
- Per-pixel set at an edge: spk_in[i] & ~acky & ~q_latch[i] (& refractory clear when enabled). q_latch[i]=1 the next cycle (latency 1).
- Per-pixel clear at an edge: acky & ackx_pulse[i]. q_latch[i]=0 the next cycle.
- Set and clear on the same pixel in the same cycle cannot both be true, because set requires ~acky.
- Spikes while acky=1 are blocked: once the row is selected, further spikes from the same row are prohibited.
- Dropped spike: any i with spk_in[i]=1 whose set is blocked (acky=1, q_latch[i]=1, or refractory).
  - drop_cnt += popcount of such i per cycle.
  - Saturates at all-ones and never wraps.
- FSM states: IDLE, REQ, SEL, RELEASE.
  - IDLE: reqy=0. Goes to REQ when |q_latch=1.
  - REQ: reqy=1. Goes to SEL when acky=1.
  - SEL: reqy=|q_latch. Goes to RELEASE when |q_latch=0 (all columns served). Goes to REQ if acky falls while latches remain (arbiter preempted).
  - RELEASE: reqy=0, waits for acky=0. Then goes to IDLE, or to REQ if |q_latch (spikes latched in the same edge acky is seen low).
- acky asserted in IDLE or RELEASE (protocol error): no state change except for the clear rules; pixels stay blocked while acky=1.
- rst mid-handshake: everything clears immediately at that edge; the arbiter sees reqy drop.
- ackx_pulse with acky=0: ignored.

Optional Feature:
- Macro PIXEL_REFRACTORY_EN.
- Defined: each pixel has an 8-bit counter loaded with REFR_CYC on clear. It decrements each cycle while nonzero, and set is blocked while it is nonzero. Spikes arriving while blocked count as dropped.
- Undefined: no counters; a pixel can be set again in the first cycle after the clear cycle, provided acky=0.

Decomposition:
- Shared package pixel_aer_pkg holds:
  - FSM state enum (IDLE, REQ, SEL, RELEASE), 2-bit encoding.
  - Default REFR_W=8 constant.
  - Saturating-add helper function.
- One sub-module is natural: pixel_cell_sync. It holds one latch plus the optional refractory counter and outputs q and blocked. It is instantiated N_COLS times via generate.

Test Plan (N_COLS=8, DROP_W=8, REFR_CYC=4):
- Reset: rst=1 for 2 cycles with spk_in=8'hFF, then rst=0 with spk_in=0 → q_latch=0, reqy=0, drop_cnt=0 throughout the reset cycles.
- Single spike: spk_in=8'h04 for 1 cycle → q_latch=8'h04 next cycle; reqy=1. Drive acky=1 → reqx=8'h04. Drive ackx_pulse=8'h04 → q_latch=0, reqy=0, state RELEASE. Drop acky → IDLE.
- Blocking during selection: spikes on cols 0,1 latched, acky=1. spk_in=8'h81 for 3 cycles → q_latch stays 8'h03, drop_cnt=6 (col0 dropped ×3, col7 ×3).
- Preemption: q_latch=8'h03, acky=1, ackx_pulse=8'h01, then acky falls → q_latch=8'h02, FSM REQ, reqy=1, reqx=0.
- Saturation: hold spk_in=8'hFF with acky=1 for 40 cycles → drop_cnt=8'hFF, no wrap.
- With PIXEL_REFRACTORY_EN: clear col 3, then spk_in[3]=1 on each of the next 5 cycles → blocked for 4 cycles (drop_cnt+4), latched on cycle 5. Without the macro: latched on the first cycle after clear with acky=0.
